// File: rtl/rr_bus_arbiter4_if.sv
// Bundle of the four requester channels, the shared downstream channel and the
// arbitration status seen by the round-robin bus arbiter.
interface rr_bus_arbiter4_if #(
    parameter int WIDTH = 32
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_last;
    logic [3:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_last;
    logic               out_ready;
    logic [1:0]         sel;
    logic [3:0]         gnt;
    logic               busy;

    // Arbiter side: owns grant, select and the downstream beat qualifiers.
    modport master (
        input  req,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output out_last,
        output sel,
        output gnt,
        output busy
    );

    // Requesters plus the downstream port, as seen from outside the arbiter.
    modport slave (
        output req,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_last,
        input  sel,
        input  gnt,
        input  busy
    );
endinterface

// File: rtl/rr_bus_arbiter4.sv
// Four-way round-robin burst arbiter: holds one requester on the shared 32-bit
// channel for a burst (bounded by BURST_MAX beats), then rotates priority.
module rr_bus_arbiter4 #(
    parameter int WIDTH     = 32,
    parameter int BURST_MAX = 8
) (
    input logic              clk,
    input logic              rstn,
    rr_bus_arbiter4_if.master bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_MAX - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic [1:0] ptr_q, ptr_d;

    logic [1:0] winner;
    logic       req_g;
    logic       last_g;
    logic       xfer;

    // First requester found scanning from the slot after the last owner;
    // ptr+4 wraps back onto the previous owner, so it is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        logic       found;
        w     = p;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign winner = rr_pick(bus.req, ptr_q);
    assign req_g  = bus.req[sel_q];
    assign last_g = req_g & (bus.in_last[sel_q] | (beat_cnt_q == LAST_BEAT));
    assign xfer   = (state_q == BUSY) & req_g & bus.out_ready;

    // Downstream channel: a pure mux on the registered select.
    assign bus.out_data  = bus.in_data[sel_q*WIDTH +: WIDTH];
    assign bus.out_valid = (state_q == BUSY) & req_g;
    assign bus.out_last  = (state_q == BUSY) & last_g;
    assign bus.in_ready  = ((state_q == BUSY) & req_g & bus.out_ready)
                           ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q == BUSY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            gnt_q      <= 4'b0000;
            beat_cnt_q <= 8'd0;
            ptr_q      <= 2'd3;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        ptr_d      = ptr_q;
        if (state_q == IDLE) begin
            gnt_d = 4'b0000;
            if (|bus.req) begin
                sel_d      = winner;
                gnt_d      = 4'b0001 << winner;
                beat_cnt_d = 8'd0;
                state_d    = BUSY;
            end
        end else begin
            // An abandoned request releases without a beat; otherwise a
            // last-beat transfer ends the burst and the owner drops to lowest priority.
            if (!req_g || (xfer && last_g)) begin
                ptr_d      = sel_q;
                gnt_d      = 4'b0000;
                beat_cnt_d = 8'd0;
                state_d    = IDLE;
            end else if (xfer) begin
                beat_cnt_d = beat_cnt_q + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Directed bench for rr_bus_arbiter4: grant order, burst limit, backpressure,
// abandoned bursts and asynchronous reset, against hand-computed expectations.
module tb_rr_bus_arbiter4;
    localparam int WIDTH = 32;

    logic clk;
    logic rstn;
    int   errs;
    int   checks;

    logic [31:0] dat [4];
    logic [3:0]  exp_gnt [5];

    rr_bus_arbiter4_if #(.WIDTH(WIDTH)) bus ();

    rr_bus_arbiter4 #(.WIDTH(WIDTH), .BURST_MAX(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errs    = 0;
        checks  = 0;
        dat[0]  = 32'hA5A5_0001;
        dat[1]  = 32'hB000_0011;
        dat[2]  = 32'hC000_0022;
        dat[3]  = 32'hD000_0033;
        exp_gnt[0] = 4'b0010;
        exp_gnt[1] = 4'b0100;
        exp_gnt[2] = 4'b1000;
        exp_gnt[3] = 4'b0001;
        exp_gnt[4] = 4'b0010;

        rstn          = 1'b0;
        bus.req       = 4'b0000;
        bus.in_last   = 4'b0000;
        bus.out_ready = 1'b0;
        bus.in_data   = {dat[3], dat[2], dat[1], dat[0]};
        #3;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_sel", 32'(bus.sel), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_out_last", 32'(bus.out_last), 32'h0);
        tick();
        rstn = 1'b1;

        // Single-beat burst from requester 0 right after reset.
        bus.req       = 4'b0001;
        bus.in_last   = 4'b0001;
        bus.out_ready = 1'b1;
        #1;
        chk("t1_idle", 32'(bus.busy), 32'h0);
        tick();
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        chk("t1_out_valid", 32'(bus.out_valid), 32'h1);
        chk("t1_out_data", bus.out_data, 32'hA5A5_0001);
        chk("t1_out_last", 32'(bus.out_last), 32'h1);
        chk("t1_in_ready", 32'(bus.in_ready), 32'h1);
        bus.req = 4'b0000;
        tick();
        chk("t1_release_busy", 32'(bus.busy), 32'h0);
        chk("t1_release_gnt", 32'(bus.gnt), 32'h0);

        // All four requesting, single-beat bursts; ptr=0 so rotation starts at 1.
        bus.req     = 4'b1111;
        bus.in_last = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t2_gnt%0d", k), 32'(bus.gnt), 32'(exp_gnt[k]));
            chk($sformatf("t2_data%0d", k), bus.out_data,
                dat[(k + 1) % 4]);
            tick();
            chk($sformatf("t2_gap%0d", k), 32'(bus.gnt), 32'h0);
        end
        bus.req = 4'b0000;
        tick();

        // Requester 2 alone, never last: forced end after 8 beats.
        bus.req     = 4'b0100;
        bus.in_last = 4'b0000;
        tick();
        chk("t3_sel", 32'(bus.sel), 32'h2);
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("t3_last%0d", b), 32'(bus.out_last), (b == 7) ? 32'h1 : 32'h0);
            chk($sformatf("t3_rdy%0d", b), 32'(bus.in_ready), 32'h4);
            tick();
        end
        chk("t3_idle", 32'(bus.busy), 32'h0);
        tick();
        chk("t3_regrant", 32'(bus.gnt), 32'h4);
        bus.req = 4'b0000;
        #1;
        chk("t3_abandon_valid", 32'(bus.out_valid), 32'h0);
        tick();
        chk("t3_abandon_idle", 32'(bus.busy), 32'h0);

        // Requester 1 with a 5-cycle stall after two beats.
        bus.req = 4'b0010;
        tick();
        chk("t4_sel", 32'(bus.sel), 32'h1);
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("t4_pre_last%0d", b), 32'(bus.out_last), 32'h0);
            tick();
        end
        bus.out_ready = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("t4_stall_valid%0d", s), 32'(bus.out_valid), 32'h1);
            chk($sformatf("t4_stall_rdy%0d", s), 32'(bus.in_ready), 32'h0);
            chk($sformatf("t4_stall_sel%0d", s), 32'(bus.sel), 32'h1);
            chk($sformatf("t4_stall_last%0d", s), 32'(bus.out_last), 32'h0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        for (int b = 2; b < 8; b++) begin
            chk($sformatf("t4_last%0d", b), 32'(bus.out_last), (b == 7) ? 32'h1 : 32'h0);
            chk($sformatf("t4_rdy%0d", b), 32'(bus.in_ready), 32'h2);
            tick();
        end
        chk("t4_idle", 32'(bus.busy), 32'h0);
        bus.req = 4'b0000;
        tick();

        // Requester 3 abandons after two beats; then 0 wins over 3.
        bus.req = 4'b1000;
        tick();
        chk("t5_sel", 32'(bus.sel), 32'h3);
        tick();
        tick();
        bus.req = 4'b0000;
        #1;
        chk("t5_drop_valid", 32'(bus.out_valid), 32'h0);
        chk("t5_drop_rdy", 32'(bus.in_ready), 32'h0);
        tick();
        chk("t5_idle", 32'(bus.busy), 32'h0);
        bus.req = 4'b1001;
        tick();
        chk("t5_gnt", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0000;
        tick();
        chk("t5_release", 32'(bus.busy), 32'h0);

        // Asynchronous reset in the middle of a burst on requester 2.
        bus.req = 4'b0100;
        tick();
        chk("t6_gnt", 32'(bus.gnt), 32'h4);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(bus.gnt), 32'h0);
        chk("t6_rst_sel", 32'(bus.sel), 32'h0);
        chk("t6_rst_busy", 32'(bus.busy), 32'h0);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'h0);
        bus.req = 4'b0110;
        tick();
        rstn = 1'b1;
        tick();
        chk("t6_after_rst_gnt", 32'(bus.gnt), 32'h2);
        chk("t6_after_rst_data", bus.out_data, dat[1]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
